neuron_layer_ctrl: RTL and testbench

- Sequences one shared fixed-point multiply-accumulate datapath across all neurons of a dense layer.
- Takes an input vector and a bias vector, then streams weights from an external synchronous weight memory.
- Accumulates, adds bias, saturates and applies ReLU, then emits one result per neuron over a valid/ready handshake.
- Sits between the input/bias fileread sources and the next layer. It replaces NUM_OUTPUTS parallel combinational neurons with one time-multiplexed unit.

---
 rtl/neuron_layer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_neuron_layer_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_ctrl.sv
// rtl/neuron_layer_ctrl.sv - time-multiplexed fixed-point MAC sequencer for one dense layer
// One multiplier walks every neuron in turn; weights stream from a synchronous memory.
module neuron_layer_ctrl #(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_OUTPUTS = 1,
  parameter int DATA_W      = 32,
  parameter int FRAC_W      = 16,
  parameter int RELU        = 1,
  parameter int AW          = (NUM_INPUTS * NUM_OUTPUTS > 1) ? $clog2(NUM_INPUTS * NUM_OUTPUTS) : 1,
  localparam int JW         = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_INPUTS*DATA_W-1:0]  in_vec,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] bias_vec,
  output logic                          w_rd_en,
  output logic [AW-1:0]                 w_addr,
  input  logic [DATA_W-1:0]             w_data,
  output logic                          busy,
  output logic                          out_valid,
  output logic [JW-1:0]                 out_idx,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic                          done
);

  localparam int IW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + $clog2(NUM_INPUTS) + 1;

  localparam logic [IW-1:0] I_LAST = IW'(NUM_INPUTS - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NUM_OUTPUTS - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;

  logic [2:0]               state;
  logic [IW-1:0]            i;
  logic [JW-1:0]            j;
  logic signed [ACC_W-1:0]  acc;
  logic [DATA_W-1:0]        in_lat   [NUM_INPUTS];
  logic [DATA_W-1:0]        bias_lat [NUM_OUTPUTS];

  logic                     mac_en;
  logic [IW-1:0]            mac_idx;
  logic signed [DATA_W-1:0] mul_a;
  logic signed [DATA_W-1:0] mul_b;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shr;
  logic [DATA_W-1:0]        result;

  assign busy = (state != S_IDLE);

  // The weight for index i-1 arrives while index i is being issued; DRAIN absorbs the last one.
  always_comb begin
    mac_en  = 1'b0;
    mac_idx = I_LAST;
    if (state == S_RUN && i != '0) begin
      mac_en  = 1'b1;
      mac_idx = i - IW'(1);
    end else if (state == S_DRAIN) begin
      mac_en  = 1'b1;
    end
  end

  assign mul_a    = in_lat[mac_idx];
  assign mul_b    = w_data;
  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  always_comb begin
    bias_ext = {{(ACC_W-DATA_W){bias_lat[j][DATA_W-1]}}, bias_lat[j]};
    sum      = acc + (bias_ext <<< FRAC_W);
    shr      = sum >>> FRAC_W;
    if (shr > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (shr < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
    end else begin
      result = shr[DATA_W-1:0];
    end
    if (RELU != 0 && shr[ACC_W-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && start) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        in_lat[k] <= in_vec[k*DATA_W +: DATA_W];
      end
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        bias_lat[k] <= bias_vec[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      i         <= '0;
      j         <= '0;
      acc       <= '0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            i       <= '0;
            j       <= '0;
            acc     <= '0;
            w_rd_en <= 1'b1;
            w_addr  <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (mac_en) begin
            acc <= acc + prod_ext;
          end
          if (i == I_LAST) begin
            w_rd_en <= 1'b0;
            state   <= S_DRAIN;
          end else begin
            i      <= i + IW'(1);
            w_addr <= w_addr + AW'(1);
          end
        end
        S_DRAIN: begin
          acc   <= acc + prod_ext;
          state <= S_FINISH;
        end
        S_FINISH: begin
          out_data  <= result;
          out_idx   <= j;
          out_valid <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (j == J_LAST) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              // w_addr still holds the last address of neuron j, so +1 is the next row.
              j       <= j + JW'(1);
              i       <= '0;
              acc     <= '0;
              w_rd_en <= 1'b1;
              w_addr  <= w_addr + AW'(1);
              state   <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// tb/tb_neuron_layer_ctrl.sv - scoreboard bench for neuron_layer_ctrl
// Instances a (RELU=1) and b (RELU=0) share stimulus; c is a two-neuron layer.
module tb_neuron_layer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        start_s;
  logic [63:0] in_s;
  logic [31:0] bias_s;
  logic        ready_s;
  logic [31:0] wmem_s [2];

  logic        rd_a, rd_b, busy_a, busy_b, ov_a, ov_b, done_a, done_b;
  logic [0:0]  addr_a, addr_b, idx_a, idx_b;
  logic [31:0] wd_a, wd_b, od_a, od_b;

  logic        start_c, ready_c, rd_c, busy_c, ov_c, done_c;
  logic [63:0] in_c, bias_c;
  logic [31:0] wmem_c [4];
  logic [1:0]  addr_c;
  logic [0:0]  idx_c;
  logic [31:0] wd_c, od_c;

  neuron_layer_ctrl #(.NUM_INPUTS(2), .NUM_OUTPUTS(1), .DATA_W(32), .FRAC_W(16), .RELU(1)) u_a (
    .clk(clk), .rst(rst), .start(start_s), .in_vec(in_s), .bias_vec(bias_s),
    .w_rd_en(rd_a), .w_addr(addr_a), .w_data(wd_a), .busy(busy_a),
    .out_valid(ov_a), .out_idx(idx_a), .out_data(od_a), .out_ready(ready_s), .done(done_a));

  neuron_layer_ctrl #(.NUM_INPUTS(2), .NUM_OUTPUTS(1), .DATA_W(32), .FRAC_W(16), .RELU(0)) u_b (
    .clk(clk), .rst(rst), .start(start_s), .in_vec(in_s), .bias_vec(bias_s),
    .w_rd_en(rd_b), .w_addr(addr_b), .w_data(wd_b), .busy(busy_b),
    .out_valid(ov_b), .out_idx(idx_b), .out_data(od_b), .out_ready(ready_s), .done(done_b));

  neuron_layer_ctrl #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .DATA_W(32), .FRAC_W(16), .RELU(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .in_vec(in_c), .bias_vec(bias_c),
    .w_rd_en(rd_c), .w_addr(addr_c), .w_data(wd_c), .busy(busy_c),
    .out_valid(ov_c), .out_idx(idx_c), .out_data(od_c), .out_ready(ready_c), .done(done_c));

  // Weight memories return a poison word when not read, so mistimed sampling shows up.
  always @(posedge clk) begin
    wd_a <= rd_a ? wmem_s[addr_a] : 32'hDEAD_BEEF;
    wd_b <= rd_b ? wmem_s[addr_b] : 32'hDEAD_BEEF;
    wd_c <= rd_c ? wmem_c[addr_c] : 32'hDEAD_BEEF;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  logic [32:0] q_a [$];
  logic [32:0] q_b [$];
  logic [32:0] q_c [$];
  int nd_a = 0, nd_b = 0, nd_c = 0;
  logic        stall_c = 1'b0;
  logic [32:0] held_c;

  always @(negedge clk) begin
    if (!rst && ov_a && ready_s) begin
      if (q_a.size() == 0) chk("a_spurious", {63'b0, ov_a}, 64'd0);
      else chk("a_result", {idx_a, od_a}, q_a.pop_front());
    end
    if (!rst && ov_b && ready_s) begin
      if (q_b.size() == 0) chk("b_spurious", {63'b0, ov_b}, 64'd0);
      else chk("b_result", {idx_b, od_b}, q_b.pop_front());
    end
    if (!rst && ov_c && ready_c) begin
      if (q_c.size() == 0) chk("c_spurious", {63'b0, ov_c}, 64'd0);
      else chk("c_result", {idx_c, od_c}, q_c.pop_front());
    end
    if (done_a) nd_a++;
    if (done_b) nd_b++;
    if (done_c) nd_c++;
  end

  always @(negedge clk) begin
    if (!rst && stall_c) chk("c_hold_stable", {ov_c, idx_c, od_c}, {1'b1, held_c});
    if (ov_c) chk("c_no_read_in_emit", rd_c, 0);
    stall_c = ov_c && !ready_c;
    held_c  = {idx_c, od_c};
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_ab(input logic [63:0] vin, input logic [31:0] vb, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [31:0] ea, input logic [31:0] eb,
                        input string tag);
    wmem_s[0] = w0;
    wmem_s[1] = w1;
    in_s      = vin;
    bias_s    = vb;
    ready_s   = 1'b1;
    q_a.push_back({1'b0, ea});
    q_b.push_back({1'b0, eb});
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk({tag, "_rd_t1"}, rd_a, 1);
    chk({tag, "_addr_t1"}, addr_a, 0);
    chk({tag, "_busy_t1"}, busy_a, 1);
    tick();
    chk({tag, "_addr_t2"}, {rd_a, addr_a}, 2'b11);
    tick();
    chk({tag, "_drain_rd"}, rd_a, 0);
    tick();
    chk({tag, "_finish_valid"}, {ov_a, ov_b}, 2'b00);
    tick();
    chk({tag, "_emit_valid"}, {ov_a, ov_b}, 2'b11);
    tick();
    chk({tag, "_done"}, {done_a, done_b, busy_a, ov_a}, 4'b1100);
    tick();
    chk({tag, "_done_pulse"}, {done_a, done_b}, 2'b00);
  endtask

  int snap;

  initial begin
    rst = 1'b1;
    start_s = 1'b0; in_s = '0; bias_s = '0; ready_s = 1'b1;
    start_c = 1'b0; in_c = '0; bias_c = '0; ready_c = 1'b1;
    for (int k = 0; k < 2; k++) wmem_s[k] = '0;
    for (int k = 0; k < 4; k++) wmem_c[k] = '0;
    tick(3);
    chk("reset_a", {busy_a, rd_a, ov_a, done_a, addr_a, idx_a, od_a}, 0);
    chk("reset_c", {busy_c, rd_c, ov_c, done_c, addr_c, idx_c, od_c}, 0);
    rst = 1'b0;
    tick();

    run_ab({32'h0002_0000, 32'h0001_0000}, 32'h0000_4000, 32'h0000_8000, 32'h0000_4000,
           32'h0001_4000, 32'h0001_4000, "basic");
    run_ab({32'h0002_0000, 32'h0001_0000}, 32'h0, 32'hFFFF_0000, 32'h0,
           32'h0000_0000, 32'hFFFF_0000, "negative");
    run_ab({32'h7FFF_0000, 32'h7FFF_0000}, 32'h0, 32'h0002_0000, 32'h0002_0000,
           32'h7FFF_FFFF, 32'h7FFF_FFFF, "sat_pos");
    run_ab({32'h7FFF_0000, 32'h7FFF_0000}, 32'h0, 32'hFFFE_0000, 32'hFFFE_0000,
           32'h0000_0000, 32'h8000_0000, "sat_neg");

    // two neurons with a 5-cycle stall on the first result
    wmem_c[0] = 32'h0001_0000; wmem_c[1] = 32'h0; wmem_c[2] = 32'h0; wmem_c[3] = 32'h0001_0000;
    in_c = {32'h0005_0000, 32'h0003_0000};
    bias_c = '0;
    ready_c = 1'b0;
    q_c.push_back({1'b0, 32'h0003_0000});
    q_c.push_back({1'b1, 32'h0005_0000});
    snap = nd_c;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("c_addr0", {rd_c, addr_c}, 3'b100);
    tick();
    chk("c_addr1", {rd_c, addr_c}, 3'b101);
    tick(3);
    chk("c_first_valid", {ov_c, idx_c, od_c}, {1'b1, 1'b0, 32'h0003_0000});
    tick(5);
    ready_c = 1'b1;
    tick();
    chk("c_addr2", {rd_c, addr_c, ov_c}, 4'b1100);
    tick();
    chk("c_addr3", {rd_c, addr_c}, 3'b111);
    tick(2);
    chk("c_second_not_yet", ov_c, 0);
    tick();
    chk("c_second_valid", {ov_c, idx_c}, 2'b11);
    tick();
    chk("c_done", {done_c, busy_c}, 2'b10);
    tick();
    chk("c_done_count", nd_c - snap, 1);

    // start pulses during RUN and a stalled EMIT are ignored; start in the done cycle is taken
    wmem_s[0] = 32'h0000_8000; wmem_s[1] = 32'h0000_4000;
    in_s = {32'h0002_0000, 32'h0001_0000};
    bias_s = 32'h0000_4000;
    ready_s = 1'b0;
    q_a.push_back({1'b0, 32'h0001_4000});
    q_b.push_back({1'b0, 32'h0001_4000});
    snap = nd_a;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("busy_start_drain", {busy_a, rd_a}, 2'b10);
    tick(2);
    chk("busy_stall_valid", ov_a, 1);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("busy_emit_held", {ov_a, busy_a}, 2'b11);
    ready_s = 1'b1;
    tick();
    chk("busy_done", {done_a, busy_a}, 2'b10);
    q_a.push_back({1'b0, 32'h0001_4000});
    q_b.push_back({1'b0, 32'h0001_4000});
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("b2b_restart", {busy_a, rd_a, addr_a, done_a}, 4'b1100);
    tick(4);
    chk("b2b_valid", {ov_a, ov_b}, 2'b11);
    tick(2);
    chk("b2b_done_count", nd_a - snap, 2);

    // reset while neuron 0 is running
    snap = nd_a;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_midop", {busy_a, ov_a, rd_a, busy_b}, 4'b0000);
    tick(8);
    chk("rst_no_done", nd_a - snap, 0);
    chk("rst_no_result", ov_a, 0);
    run_ab({32'h0002_0000, 32'h0001_0000}, 32'h0000_4000, 32'h0000_8000, 32'h0000_4000,
           32'h0001_4000, 32'h0001_4000, "after_rst");

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    chk("queue_c_empty", q_c.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
